icap_reboot_ctrl: RTL and testbench

//   Multiboot reboot controller. Arbitrates reboot requests from N_REQ sources
//   (watchdog, host command, button, ...), latches the winner's 24-bit SPI boot

---
 rtl/icap_reboot_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_icap_reboot_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_reboot_ctrl.sv
// -----------------------------------------------------------------------------
// icap_reboot_ctrl
//
// Multiboot reboot controller for Spartan-6. Several sources (watchdog, host
// command, push button, ...) may request a reboot. The lowest-numbered active
// requester wins. Its 24-bit SPI boot address is latched, and after a guard
// interval the 16-word IPROG command sequence is streamed into the ICAP pins.
// The ICAP_SPARTAN6 primitive lives in the parent; this block only drives it.
//
// Parameters
//   N_REQ          number of requesters (1..8)
//   GUARD_CYCLES   cycles between the grant and the first ICAP word (>= 1)
//   FALLBACK_ADDR  golden image address written to GENERAL3/GENERAL4
//   BITSWAP        1: bit-reverse every byte of the ICAP word, 0: raw word
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        requests are only accepted while high (and only in IDLE)
//   req           level reboot request, one bit per source
//   req_addr      boot address per source, slice i = [24*i+23:24*i]
//   icap_busy     ICAP BUSY pin; while high the current word is held
//   icap_ce_n     ICAP CE, active low
//   icap_write_n  ICAP WRITE, active low means write
//   icap_i        ICAP data word
//   active        high while guarding or sending
//   grant_id      index of the granted requester (valid while active/done)
//   done          sticky, high once all 16 words were accepted
// -----------------------------------------------------------------------------
module icap_reboot_ctrl #(
   parameter int          N_REQ         = 4,
   parameter int          GUARD_CYCLES  = 16,
   parameter logic [23:0] FALLBACK_ADDR = 24'h0,
   parameter int          BITSWAP       = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [N_REQ-1:0]    req,
   input  logic [24*N_REQ-1:0] req_addr,
   input  logic                icap_busy,
   output logic                icap_ce_n,
   output logic                icap_write_n,
   output logic [15:0]         icap_i,
   output logic                active,
   output logic [2:0]          grant_id,
   output logic                done
);

   localparam int CW = $clog2(GUARD_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GUARD = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_t        state_reg,    state_next;
   logic [CW-1:0] cnt_reg,      cnt_next;
   logic [3:0]    w_reg,        w_next;
   logic [23:0]   addr_reg,     addr_next;
   logic [2:0]    gid_reg,      gid_next;

   logic          ce_n_reg,     ce_n_next;
   logic          wr_n_reg,     wr_n_next;
   logic [15:0]   data_reg,     data_next;
   logic          active_reg,   active_next;
   logic          done_reg,     done_next;

   // ---------------------------------------------------------------------
   // Fixed-priority arbiter: lowest set index wins
   // ---------------------------------------------------------------------
   logic          any_req;
   logic [2:0]    win_id;
   logic [23:0]   win_addr;

   assign any_req = |req;

   always_comb begin
      win_id   = '0;
      win_addr = '0;
      // Scan from the top down so the lowest active index is written last.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_id   = 3'(i);
            win_addr = req_addr[24*i +: 24];
         end
      end
   end

   // ---------------------------------------------------------------------
   // IPROG word table
   // ---------------------------------------------------------------------
   function automatic logic [15:0] iprog_word(input logic [3:0] idx,
                                              input logic [23:0] a);
      logic [15:0] word;
      case (idx)
         4'd0:    word = 16'hFFFF;                       // dummy
         4'd1:    word = 16'hFFFF;                       // dummy
         4'd2:    word = 16'hAA99;                       // sync word, high
         4'd3:    word = 16'h5566;                       // sync word, low
         4'd4:    word = 16'h3261;                       // write GENERAL1
         4'd5:    word = a[15:0];                        // multiboot addr low
         4'd6:    word = 16'h3281;                       // write GENERAL2
         4'd7:    word = {8'h0B, a[23:16]};              // SPI read opcode + addr high
         4'd8:    word = 16'h32A1;                       // write GENERAL3
         4'd9:    word = FALLBACK_ADDR[15:0];            // golden addr low
         4'd10:   word = 16'h32C1;                       // write GENERAL4
         4'd11:   word = {8'h0B, FALLBACK_ADDR[23:16]};  // opcode + golden addr high
         4'd12:   word = 16'h30A1;                       // write CMD
         4'd13:   word = 16'h000E;                       // IPROG
         default: word = 16'h2000;                       // NOOPs (14, 15)
      endcase
      return word;
   endfunction

   // The word for the index that will be on the bus after this edge. It uses
   // the latched address only, so req/req_addr never reach icap_i directly.
   logic [15:0] raw_word;
   logic [15:0] swap_word;

   assign raw_word = iprog_word(w_next, addr_reg);

   // ICAP on Spartan-6 expects each byte bit-reversed relative to the
   // bitstream order; BITSWAP selects whether that is done here.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_swap
         if (BITSWAP != 0) begin : g_rev
            assign swap_word[gi] = raw_word[(gi / 8) * 8 + 7 - (gi % 8)];
         end else begin : g_raw
            assign swap_word[gi] = raw_word[gi];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      w_next     = w_reg;
      addr_next  = addr_reg;
      gid_next   = gid_reg;

      case (state_reg)
         S_IDLE: begin
            // Grant and address latch share one edge.
            if (enable && any_req) begin
               state_next = S_GUARD;
               cnt_next   = CW'(GUARD_CYCLES);
               addr_next  = win_addr;
               gid_next   = win_id;
            end
         end

         S_GUARD: begin
            // Counts GUARD_CYCLES down after the grant edge; the extra cycle
            // spent at zero puts the first word on the bus exactly
            // GUARD_CYCLES+1 edges after the grant.
            if (cnt_reg == '0) begin
               state_next = S_SEND;
               w_next     = 4'd0;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end

         S_SEND: begin
            // The word currently on icap_i is consumed on any edge where BUSY
            // is low; otherwise index and data are held.
            if (!icap_busy) begin
               if (w_reg == 4'd15) begin
                  state_next = S_DONE;
               end else begin
                  w_next = w_reg + 4'd1;
               end
            end
         end

         S_DONE: begin
            // Terminal until reset.
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from the next state, so every pin is a flop output
   // ---------------------------------------------------------------------
   always_comb begin
      ce_n_next   = 1'b1;
      wr_n_next   = 1'b1;
      data_next   = 16'hFFFF;
      active_next = 1'b0;
      done_next   = 1'b0;

      case (state_next)
         S_GUARD: begin
            wr_n_next   = 1'b0;
            active_next = 1'b1;
         end
         S_SEND: begin
            ce_n_next   = 1'b0;
            wr_n_next   = 1'b0;
            data_next   = swap_word;
            active_next = 1'b1;
         end
         S_DONE: begin
            done_next = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         w_reg      <= '0;
         addr_reg   <= '0;
         gid_reg    <= '0;
         ce_n_reg   <= 1'b1;
         wr_n_reg   <= 1'b1;
         data_reg   <= 16'hFFFF;
         active_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         w_reg      <= w_next;
         addr_reg   <= addr_next;
         gid_reg    <= gid_next;
         ce_n_reg   <= ce_n_next;
         wr_n_reg   <= wr_n_next;
         data_reg   <= data_next;
         active_reg <= active_next;
         done_reg   <= done_next;
      end
   end

   assign icap_ce_n    = ce_n_reg;
   assign icap_write_n = wr_n_reg;
   assign icap_i       = data_reg;
   assign active       = active_reg;
   assign grant_id     = gid_reg;
   assign done         = done_reg;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icap_reboot_ctrl
//
// Self-checking bench for icap_reboot_ctrl. Two instances: the default build
// (BITSWAP=1, FALLBACK=0, GUARD=16) and a raw build (BITSWAP=0,
// FALLBACK=24'h040000, GUARD=4). Expected ICAP words are pushed to a queue
// when a request is driven and popped by a monitor whenever a word is
// accepted (CE low, BUSY low).
// -----------------------------------------------------------------------------
module tb_icap_reboot_ctrl;

   localparam int G  = 16;
   localparam int G6 = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        enable, b_enable;
   logic [3:0]  req, b_req;
   logic [95:0] req_addr, b_req_addr;
   logic        icap_busy, b_icap_busy;
   logic        icap_ce_n, b_icap_ce_n;
   logic        icap_write_n, b_icap_write_n;
   logic [15:0] icap_i, b_icap_i;
   logic        active, b_active;
   logic [2:0]  grant_id, b_grant_id;
   logic        done, b_done;

   icap_reboot_ctrl #(
      .N_REQ(4), .GUARD_CYCLES(G), .FALLBACK_ADDR(24'h000000), .BITSWAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_addr(req_addr),
      .icap_busy(icap_busy), .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n),
      .icap_i(icap_i), .active(active), .grant_id(grant_id), .done(done)
   );

   icap_reboot_ctrl #(
      .N_REQ(4), .GUARD_CYCLES(G6), .FALLBACK_ADDR(24'h040000), .BITSWAP(0)
   ) dut6 (
      .clk(clk), .rst_n(rst_n), .enable(b_enable), .req(b_req), .req_addr(b_req_addr),
      .icap_busy(b_icap_busy), .icap_ce_n(b_icap_ce_n), .icap_write_n(b_icap_write_n),
      .icap_i(b_icap_i), .active(b_active), .grant_id(b_grant_id), .done(b_done)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp6_q[$];
   int          acc_cnt = 0;
   int          acc6_cnt = 0;
   logic [15:0] cap[16];
   logic [15:0] cap6[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference IPROG word: table plus per-byte bit reversal via streaming.
   function automatic logic [15:0] model_word(input int idx, input logic [23:0] a,
                                              input logic [23:0] f, input bit sw);
      logic [15:0] tbl[16];
      logic [15:0] r;
      logic [7:0]  hi, lo;
      tbl = '{16'hFFFF, 16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h0000,
              16'h3281, 16'h0000, 16'h32A1, 16'h0000, 16'h32C1, 16'h0000,
              16'h30A1, 16'h000E, 16'h2000, 16'h2000};
      r = tbl[idx];
      case (idx)
         5:  r = a[15:0];
         7:  r = {8'h0B, a[23:16]};
         9:  r = f[15:0];
         11: r = {8'h0B, f[23:16]};
         default: ;
      endcase
      if (sw) begin
         hi = r[15:8];
         lo = r[7:0];
         hi = {<<{hi}};
         lo = {<<{lo}};
         r  = {hi, lo};
      end
      return r;
   endfunction

   task automatic push_seq(input bit which, input logic [23:0] a);
      for (int i = 0; i < 16; i++) begin
         if (!which) exp_q.push_back(model_word(i, a, 24'h000000, 1'b1));
         else        exp6_q.push_back(model_word(i, a, 24'h040000, 1'b0));
      end
   endtask

   // Scoreboard monitors: a word is accepted at the next rising edge when
   // CE is low and BUSY is low.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && icap_ce_n === 1'b0 && icap_busy === 1'b0) begin
         if (acc_cnt < 16) cap[acc_cnt] = icap_i;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected: got %h required no word", icap_i);
         end else begin
            chk("word", icap_i, exp_q.pop_front());
         end
         chk("write_n_send", icap_write_n, 0);
         acc_cnt++;
      end
      if (rst_n === 1'b1 && b_icap_ce_n === 1'b0 && b_icap_busy === 1'b0) begin
         if (acc6_cnt < 16) cap6[acc6_cnt] = b_icap_i;
         if (exp6_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word6_unexpected: got %h required no word", b_icap_i);
         end else begin
            chk("word6", b_icap_i, exp6_q.pop_front());
         end
         acc6_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b0; req = '0; req_addr = '0; icap_busy = 1'b0;
      b_enable = 1'b0; b_req = '0; b_req_addr = '0; b_icap_busy = 1'b0;
      exp_q.delete(); exp6_q.delete();
      acc_cnt = 0; acc6_cnt = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Called just after the grant edge. Counts edges until done, optionally
   // asserts BUSY while word busy_w is on the bus, optionally changes req
   // once sending has started.
   task automatic run_to_done(input int exp_lat, input int busy_w, input int busy_len,
                              input logic [15:0] hold, input bit use_late,
                              input logic [3:0] late_req, input string tag);
      int cyc, first, bl;
      bit started;
      cyc = 0; first = -1; bl = 0; started = 0;
      while (cyc < 400 && done !== 1'b1) begin
         @(posedge clk); #1;
         cyc++;
         if (icap_busy) begin
            chk({tag, "_busy_hold"}, icap_i, hold);
            bl--;
            if (bl <= 0) icap_busy = 1'b0;
         end else if (!started && busy_w >= 0 && acc_cnt == busy_w && icap_ce_n == 1'b0) begin
            icap_busy = 1'b1;
            bl = busy_len;
            started = 1;
         end
         if (first < 0 && icap_ce_n === 1'b0) begin
            first = cyc;
            if (use_late) begin
               req = late_req;
               req_addr[23:0] = 24'hFFFFFF;
               enable = 1'b1;
            end
         end
      end
      chk({tag, "_first_word_lat"}, first, G + 1);
      chk({tag, "_done_lat"}, cyc, exp_lat);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ce_n_done"}, icap_ce_n, 1);
      chk({tag, "_write_n_done"}, icap_write_n, 1);
      chk({tag, "_data_done"}, icap_i, 16'hFFFF);
      chk({tag, "_active_done"}, active, 0);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      chk({tag, "_words"}, acc_cnt, 16);
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  rq;
      logic [95:0] addrs;   // {slot3, slot2, slot1, slot0}
      bit          go;
      int          gid;
      int          busy_w;
      int          busy_len;
      logic [15:0] hold;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cyc;
      vecs[0] = '{1'b1, 4'b0100, {24'h0, 24'h0D0100, 24'h0, 24'h0}, 1, 2, -1, 0, 16'h0};
      vecs[1] = '{1'b1, 4'b1010, {24'h778899, 24'h0, 24'h112233, 24'h0}, 1, 1, -1, 0, 16'h0};
      vecs[2] = '{1'b1, 4'b0001, {24'h0, 24'h0, 24'h0, 24'hABCDEF}, 1, 0, 6, 3, 16'h4C81};
      vecs[3] = '{1'b1, 4'b1000, {24'hFEDCBA, 24'h000001, 24'h000002, 24'h000003}, 1, 3, -1, 0, 16'h0};
      vecs[4] = '{1'b0, 4'b1111, {24'h1, 24'h2, 24'h3, 24'h4}, 0, 0, -1, 0, 16'h0};

      // Reset values, checked while reset is held
      rst_n = 1'b0;
      enable = 1'b0; req = '0; req_addr = '0; icap_busy = 1'b0;
      b_enable = 1'b0; b_req = '0; b_req_addr = '0; b_icap_busy = 1'b0;
      #12;
      chk("rst_ce_n", icap_ce_n, 1);
      chk("rst_write_n", icap_write_n, 1);
      chk("rst_data", icap_i, 16'hFFFF);
      chk("rst_active", active, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_done", done, 0);

      // Table-driven vectors
      for (int v = 0; v < 5; v++) begin
         do_reset();
         enable   = vecs[v].en;
         req      = vecs[v].rq;
         req_addr = vecs[v].addrs;
         if (vecs[v].go) push_seq(1'b0, vecs[v].addrs[24*vecs[v].gid +: 24]);
         @(posedge clk); #1;
         if (vecs[v].go) begin
            chk("grant_active", active, 1);
            chk("grant_id", grant_id, vecs[v].gid);
            chk("guard_write_n", icap_write_n, 0);
            chk("guard_ce_n", icap_ce_n, 1);
            run_to_done(G + 17 + vecs[v].busy_len, vecs[v].busy_w, vecs[v].busy_len,
                        vecs[v].hold, 1'b0, 4'b0000, "vec");
         end else begin
            repeat (50) @(posedge clk);
            #1;
            chk("dis_active", active, 0);
            chk("dis_ce_n", icap_ce_n, 1);
            chk("dis_done", done, 0);
            chk("dis_words", acc_cnt, 0);
         end
         $display("vec %0d: en=%b req=%b grant_id=%0d words=%0d done=%b",
                  v, vecs[v].en, vecs[v].rq, grant_id, acc_cnt, done);
         if (v == 0) begin
            chk("t1_word2", cap[2], 16'h5599);
            chk("t1_word5", cap[5], 16'h8000);
            chk("t1_word7", cap[7], 16'hD0B0);
         end
      end

      // Requester drops req and enable during GUARD, then a different
      // requester appears during SEND: neither disturbs the sequence.
      do_reset();
      enable = 1'b1;
      req = 4'b1010;
      req_addr = {24'h778899, 24'h0, 24'h112233, 24'h0};
      push_seq(1'b0, 24'h112233);
      @(posedge clk); #1;
      req = 4'b0000;
      enable = 1'b0;
      run_to_done(G + 17, -1, 0, 16'h0, 1'b1, 4'b0001, "t2");
      chk("t2_grant_id", grant_id, 1);
      $display("seq t2: grant_id=%0d words=%0d done=%b", grant_id, acc_cnt, done);

      // Asynchronous reset in the middle of the sequence, then a fresh request
      do_reset();
      enable = 1'b1;
      req = 4'b0100;
      req_addr = {24'h0, 24'h0D0100, 24'h0, 24'h0};
      push_seq(1'b0, 24'h0D0100);
      @(posedge clk); #1;
      cyc = 0;
      while (cyc < 100 && acc_cnt != 9) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_reached_w9", acc_cnt, 9);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_ce_n", icap_ce_n, 1);
      chk("t5_async_write_n", icap_write_n, 1);
      chk("t5_async_data", icap_i, 16'hFFFF);
      chk("t5_async_active", active, 0);
      chk("t5_async_grant_id", grant_id, 0);
      chk("t5_async_done", done, 0);
      enable = 1'b0;
      req = '0;
      exp_q.delete();
      acc_cnt = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      enable = 1'b1;
      req = 4'b1000;
      req_addr = {24'h5A5A5A, 72'h0};
      push_seq(1'b0, 24'h5A5A5A);
      @(posedge clk); #1;
      chk("t5_regrant_id", grant_id, 3);
      run_to_done(G + 17, -1, 0, 16'h0, 1'b0, 4'b0000, "t5");
      $display("seq t5: grant_id=%0d words=%0d done=%b", grant_id, acc_cnt, done);

      // Raw (unswapped) build with a non-zero fallback address
      do_reset();
      b_enable = 1'b1;
      b_req = 4'b0010;
      b_req_addr = {24'h0, 24'h0, 24'h0D0100, 24'h0};
      push_seq(1'b1, 24'h0D0100);
      @(posedge clk); #1;
      chk("t6_active", b_active, 1);
      chk("t6_grant_id", b_grant_id, 1);
      cyc = 0;
      while (cyc < 200 && b_done !== 1'b1) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t6_done_lat", cyc, G6 + 17);
      chk("t6_done", b_done, 1);
      chk("t6_queue_empty", exp6_q.size(), 0);
      chk("t6_word5", cap6[5], 16'h0100);
      chk("t6_word9", cap6[9], 16'h0000);
      chk("t6_word11", cap6[11], 16'h0B04);
      chk("t6_word13", cap6[13], 16'h000E);
      $display("seq t6: grant_id=%0d words=%0d done=%b", b_grant_id, acc6_cnt, b_done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
